// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back port arbiter in front of the register bank's single
// write port. Merges the in-order MEM/WB write (always wins) with late results
// from the long-latency unit, which wait in a small FIFO and drain into idle
// write-back slots. Exposes a pending-destination mask for decode hazard stalls.
//
// Ports:
//   clk_sig, rst_sig          clock, synchronous active-high reset
//   pipe_wr_en/rd_addr/rd_data MEM/WB write request
//   lu_valid/addr/data        long-latency result offer; lu_ready = FIFO not full
//   wr_en/rd_addr/rd_data     registered register-bank write port
//   pend_mask                 bit i set while a valid buffered entry targets reg i
//
// Optional macro WB_ARB_STATS_EN adds stall_cnt (cycles with lu_valid && !lu_ready)
// and squash_cnt (entries squashed by a pipe write), both 16-bit saturating.

module wb_arbiter #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                 clk_sig,
    input  logic                 rst_sig,
    input  logic                 pipe_wr_en,
    input  logic [AW-1:0]        pipe_rd_addr,
    input  logic [DW-1:0]        pipe_rd_data,
    input  logic                 lu_valid,
    input  logic [AW-1:0]        lu_addr,
    input  logic [DW-1:0]        lu_data,
    output logic                 lu_ready,
    output logic                 wr_en,
    output logic [AW-1:0]        rd_addr,
    output logic [DW-1:0]        rd_data,
    output logic [(2**AW)-1:0]   pend_mask
`ifdef WB_ARB_STATS_EN
    ,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          squash_cnt
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    // FIFO storage and bookkeeping
    logic [AW-1:0]    ent_addr [DEPTH];
    logic [DW-1:0]    ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;

    logic [DEPTH-1:0] ent_valid_nxt;
    logic [PW-1:0]    head_nxt;
    logic [PW-1:0]    tail_nxt;
    logic [CW-1:0]    count_nxt;
    logic             wr_en_nxt;
    logic [AW-1:0]    rd_addr_nxt;
    logic [DW-1:0]    rd_data_nxt;
    logic             pipe_act;
    logic             push;
    logic             pop;

`ifdef WB_ARB_STATS_EN
    logic [3:0]       sq_num;
    logic [16:0]      sq_sum;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Ready depends only on registered occupancy, so a same-cycle pop never raises it
    assign lu_ready = (count < CW'(DEPTH));

    // Pending mask from registered valid bits
    always_comb begin
        pend_mask = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (ent_valid[i]) pend_mask[ent_addr[i]] = 1'b1;
        end
    end

    // Next-state: arbitration, squash, push/pop
    always_comb begin
        ent_valid_nxt = ent_valid;
        head_nxt      = head;
        tail_nxt      = tail;
        count_nxt     = count;
        wr_en_nxt     = 1'b0;
        rd_addr_nxt   = rd_addr;
        rd_data_nxt   = rd_data;

        pipe_act = pipe_wr_en && (pipe_rd_addr != '0);
        // Address-0 results complete the handshake but take no slot
        push     = lu_valid && lu_ready && (lu_addr != '0);
        // Any occupied head (valid or squashed) is popped in an idle slot
        pop      = !pipe_act && (count != '0);

        // A pipe write supersedes every buffered result to the same register
        if (pipe_act) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ent_addr[i] == pipe_rd_addr) ent_valid_nxt[i] = 1'b0;
            end
        end

        if (pipe_act) begin
            wr_en_nxt   = 1'b1;
            rd_addr_nxt = pipe_rd_addr;
            rd_data_nxt = pipe_rd_data;
        end else if (pop && ent_valid[head]) begin
            wr_en_nxt   = 1'b1;
            rd_addr_nxt = ent_addr[head];
            rd_data_nxt = ent_data[head];
        end

        if (pop) begin
            ent_valid_nxt[head] = 1'b0;
            head_nxt            = ptr_inc(head);
        end

        // Push never aliases the popped slot: push needs count<DEPTH, pop needs count>0
        if (push) begin
            ent_valid_nxt[tail] = !(pipe_act && (lu_addr == pipe_rd_addr));
            tail_nxt            = ptr_inc(tail);
        end

        if (push && !pop)      count_nxt = count + CW'(1);
        else if (!push && pop) count_nxt = count - CW'(1);
    end

`ifdef WB_ARB_STATS_EN
    // Squashed entries this cycle: matching valid entries plus an invalid-on-arrival push
    always_comb begin
        sq_num = '0;
        if (pipe_act) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (ent_valid[i] && (ent_addr[i] == pipe_rd_addr)) sq_num = sq_num + 4'd1;
            end
            if (push && (lu_addr == pipe_rd_addr)) sq_num = sq_num + 4'd1;
        end
        sq_sum = {1'b0, squash_cnt} + 17'(sq_num);
    end

    always_ff @(posedge clk_sig) begin
        if (rst_sig) begin
            stall_cnt  <= '0;
            squash_cnt <= '0;
        end else begin
            if (lu_valid && !lu_ready && (stall_cnt != 16'hFFFF)) stall_cnt <= stall_cnt + 16'd1;
            squash_cnt <= sq_sum[16] ? 16'hFFFF : sq_sum[15:0];
        end
    end
`endif

    // State and output registers
    always_ff @(posedge clk_sig) begin
        if (rst_sig) begin
            ent_valid <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            wr_en     <= 1'b0;
            rd_addr   <= '0;
            rd_data   <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                ent_addr[i] <= '0;
                ent_data[i] <= '0;
            end
        end else begin
            ent_valid <= ent_valid_nxt;
            head      <= head_nxt;
            tail      <= tail_nxt;
            count     <= count_nxt;
            wr_en     <= wr_en_nxt;
            rd_addr   <= rd_addr_nxt;
            rd_data   <= rd_data_nxt;
            if (push) begin
                ent_addr[tail] <= lu_addr;
                ent_data[tail] <= lu_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter (DEPTH=2, AW=5, DW=32): a directed vector
// table where each row's expectation is the state seen just after the edge that
// row is applied on, plus a hand-written backpressure sequence.

module tb_wb_arbiter;

    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic          clk_sig = 1'b0;
    logic          rst_sig;
    logic          pipe_wr_en;
    logic [AW-1:0] pipe_rd_addr;
    logic [DW-1:0] pipe_rd_data;
    logic          lu_valid;
    logic [AW-1:0] lu_addr;
    logic [DW-1:0] lu_data;
    logic          lu_ready;
    logic          wr_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [31:0]   pend_mask;
`ifdef WB_ARB_STATS_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   squash_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_sig = ~clk_sig;

    wb_arbiter #(.DEPTH(2), .AW(AW), .DW(DW)) dut (
        .clk_sig      (clk_sig),
        .rst_sig      (rst_sig),
        .pipe_wr_en   (pipe_wr_en),
        .pipe_rd_addr (pipe_rd_addr),
        .pipe_rd_data (pipe_rd_data),
        .lu_valid     (lu_valid),
        .lu_addr      (lu_addr),
        .lu_data      (lu_data),
        .lu_ready     (lu_ready),
        .wr_en        (wr_en),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .pend_mask    (pend_mask)
`ifdef WB_ARB_STATS_EN
        ,
        .stall_cnt    (stall_cnt),
        .squash_cnt   (squash_cnt)
`endif
    );

    typedef struct {
        logic        rst;
        logic        pwe;
        logic [4:0]  pa;
        logic [31:0] pd;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic        e_we;
        logic [4:0]  e_ra;
        logic [31:0] e_rd;
        logic        e_rdy;
        logic [31:0] e_pm;
    } vec_t;

    vec_t vecs [27];

    function automatic logic [31:0] m(input int n);
        return 32'(1) << n;
    endfunction

    function automatic vec_t mk(input logic rst, input logic pwe, input logic [4:0] pa,
                                input logic [31:0] pd, input logic lv, input logic [4:0] la,
                                input logic [31:0] ld, input logic e_we, input logic [4:0] e_ra,
                                input logic [31:0] e_rd, input logic e_rdy, input logic [31:0] e_pm);
        vec_t v;
        v.rst = rst; v.pwe = pwe; v.pa = pa; v.pd = pd;
        v.lv = lv; v.la = la; v.ld = ld;
        v.e_we = e_we; v.e_ra = e_ra; v.e_rd = e_rd; v.e_rdy = e_rdy; v.e_pm = e_pm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic pwe, input logic [4:0] pa, input logic [31:0] pd,
                         input logic lv, input logic [4:0] la, input logic [31:0] ld);
        rst_sig = rst; pipe_wr_en = pwe; pipe_rd_addr = pa; pipe_rd_data = pd;
        lu_valid = lv; lu_addr = la; lu_data = ld;
    endtask

    task automatic tick();
        @(posedge clk_sig);
        #1;
    endtask

    task automatic check_out(input string tag, input logic we, input logic [4:0] ra,
                             input logic [31:0] rd, input logic rdy, input logic [31:0] pm);
        check({tag, ".wr_en"},     32'(wr_en),    32'(we));
        check({tag, ".rd_addr"},   32'(rd_addr),  32'(ra));
        check({tag, ".rd_data"},   rd_data,       rd);
        check({tag, ".lu_ready"},  32'(lu_ready), 32'(rdy));
        check({tag, ".pend_mask"}, pend_mask,     pm);
    endtask

    initial begin
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        //            rst  pwe pa     pd            lv  la     ld            we  ra     rd            rdy pm
        vecs[0]  = mk(1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,32'h0);
        vecs[1]  = mk(1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,32'h0);
        vecs[2]  = mk(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,32'h0);
        // passthrough, then pipe to x0 counts as idle and holds addr/data
        vecs[3]  = mk(1'b0,1'b1,5'd5, 32'h1234,     1'b0,5'd0, 32'h0,        1'b1,5'd5, 32'h1234,     1'b1,32'h0);
        vecs[4]  = mk(1'b0,1'b1,5'd0, 32'h9999,     1'b0,5'd0, 32'h0,        1'b0,5'd5, 32'h1234,     1'b1,32'h0);
        // buffer (7,AAAA) behind three pipe writes to 3, drain in first idle slot
        vecs[5]  = mk(1'b0,1'b1,5'd3, 32'h3000,     1'b1,5'd7, 32'hAAAA,     1'b1,5'd3, 32'h3000,     1'b1,m(7));
        vecs[6]  = mk(1'b0,1'b1,5'd3, 32'h3001,     1'b0,5'd0, 32'h0,        1'b1,5'd3, 32'h3001,     1'b1,m(7));
        vecs[7]  = mk(1'b0,1'b1,5'd3, 32'h3002,     1'b0,5'd0, 32'h0,        1'b1,5'd3, 32'h3002,     1'b1,m(7));
        vecs[8]  = mk(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd7, 32'hAAAA,     1'b1,32'h0);
        vecs[9]  = mk(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd7, 32'hAAAA,     1'b1,32'h0);
        // squash a buffered entry; its later pop produces no write
        vecs[10] = mk(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd12,32'h1111,     1'b0,5'd7, 32'hAAAA,     1'b1,m(12));
        vecs[11] = mk(1'b0,1'b1,5'd12,32'h2222,     1'b0,5'd0, 32'h0,        1'b1,5'd12,32'h2222,     1'b1,32'h0);
        vecs[12] = mk(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd12,32'h2222,     1'b1,32'h0);
        vecs[13] = mk(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd12,32'h2222,     1'b1,32'h0);
        // same-cycle arrival to the register being written is enqueued invalid
        vecs[14] = mk(1'b0,1'b1,5'd13,32'h5555,     1'b1,5'd13,32'h6666,     1'b1,5'd13,32'h5555,     1'b1,32'h0);
        vecs[15] = mk(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd13,32'h5555,     1'b1,32'h0);
        // lu result to x0 is dropped
        vecs[16] = mk(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd0, 32'h7777,     1'b0,5'd13,32'h5555,     1'b1,32'h0);
        vecs[17] = mk(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd13,32'h5555,     1'b1,32'h0);
        // simultaneous push and pop
        vecs[18] = mk(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd20,32'hA020,     1'b0,5'd13,32'h5555,     1'b1,m(20));
        vecs[19] = mk(1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd21,32'hA021,     1'b1,5'd20,32'hA020,     1'b1,m(21));
        vecs[20] = mk(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,5'd21,32'hA021,     1'b1,32'h0);
        vecs[21] = mk(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd21,32'hA021,     1'b1,32'h0);
        // fill, then reset discards the buffered results
        vecs[22] = mk(1'b0,1'b1,5'd4, 32'h4444,     1'b1,5'd22,32'hB022,     1'b1,5'd4, 32'h4444,     1'b1,m(22));
        vecs[23] = mk(1'b0,1'b1,5'd4, 32'h4445,     1'b1,5'd23,32'hB023,     1'b1,5'd4, 32'h4445,     1'b0,m(22)|m(23));
        vecs[24] = mk(1'b1,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,32'h0);
        vecs[25] = mk(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,32'h0);
        vecs[26] = mk(1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b0,5'd0, 32'h0,        1'b1,32'h0);

        for (int i = 0; i < 27; i++) begin
            drive(vecs[i].rst, vecs[i].pwe, vecs[i].pa, vecs[i].pd, vecs[i].lv, vecs[i].la, vecs[i].ld);
            tick();
            check_out($sformatf("vec%0d", i), vecs[i].e_we, vecs[i].e_ra, vecs[i].e_rd,
                      vecs[i].e_rdy, vecs[i].e_pm);
        end

        // Backpressure: pipe busy while lu pushes 8, 9, then holds 10
        drive(1'b0, 1'b1, 5'd1, 32'h0101, 1'b1, 5'd8, 32'h8888);
        tick();
        check_out("bp_push8", 1'b1, 5'd1, 32'h0101, 1'b1, m(8));
        drive(1'b0, 1'b1, 5'd1, 32'h0102, 1'b1, 5'd9, 32'h9999);
        tick();
        check_out("bp_push9", 1'b1, 5'd1, 32'h0102, 1'b0, m(8) | m(9));
        drive(1'b0, 1'b1, 5'd1, 32'h0103, 1'b1, 5'd10, 32'h1010);
        check("bp_ready_held10", 32'(lu_ready), 32'h0);
        tick();
        check_out("bp_hold10", 1'b1, 5'd1, 32'h0103, 1'b0, m(8) | m(9));
        // pipe released: 8 drains, 10 still refused this cycle
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'h1010);
        tick();
        check_out("bp_drain8", 1'b1, 5'd8, 32'h8888, 1'b1, m(9));
        // 10 accepted while 9 drains
        tick();
        check_out("bp_drain9", 1'b1, 5'd9, 32'h9999, 1'b1, m(10));
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();
        check_out("bp_drain10", 1'b1, 5'd10, 32'h1010, 1'b1, 32'h0);
        tick();
        check_out("bp_empty", 1'b0, 5'd10, 32'h1010, 1'b1, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
